exibe_sequencia: RTL and testbench

//  Playback side of the memory game: reads the stored colour sequence and shows it on the LEDs,
//  so the player can then repeat it on the chaves. Each element is lit for T_ON cycles, followed by
//  T_OFF dark cycles. Sits beside the game datapath, shares the sequence ROM read port, and is

---
 rtl/exibe_sequencia_pkg.sv | 26 ++
 rtl/exibe_sequencia_temporizador.sv | 26 ++
 rtl/exibe_sequencia.sv | 117 +++++++++++
 tb/tb_exibe_sequencia.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/exibe_sequencia_pkg.sv
// Shared definitions for the sequence playback block: state codes, debug code width,
// and the timer width helper.
package exibe_sequencia_pkg;

  localparam int DB_W = 4;

  typedef enum logic [DB_W-1:0] {
    OCIOSO  = 4'd0,
    CARREGA = 4'd1,
    ACESO   = 4'd2,
    APAGADO = 4'd3,
    FINAL   = 4'd4
  } estado_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Never narrower than one bit, so T_ON = T_OFF = 1 still yields a legal counter.
  function automatic int timer_width(input int t_on, input int t_off);
    int w;
    w = $clog2(max_int(t_on, t_off));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/exibe_sequencia_temporizador.sv
// Phase timer: counts while conta is high, clears on zera, and flags fim_t when the count
// reaches the terminal value tc supplied by the sequencer for the current phase.
module exibe_sequencia_temporizador #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  input  logic [W-1:0] tc,
  output logic         fim_t
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset || zera) begin
      cnt_q <= '0;
    end else if (conta) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign fim_t = (cnt_q == tc);

endmodule

// File: rtl/exibe_sequencia.sv
// Plays the stored colour sequence on the LEDs: T_ON lit cycles then T_OFF dark cycles per
// element, elements 0..limite. Optional pause input enabled by macro EXIBE_PAUSA_EN.
module exibe_sequencia
  import exibe_sequencia_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter int T_ON   = 1000,
  parameter int T_OFF  = 500
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mostra,
  input  logic [ADDR_W-1:0] limite,
  input  logic [DATA_W-1:0] mem_dado,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] leds,
  output logic              ocupado,
  output logic              fim,
  output logic [DB_W-1:0]   db_estado
`ifdef EXIBE_PAUSA_EN
  ,
  input  logic              pausa
`endif
);

  localparam int TW = timer_width(T_ON, T_OFF);
  localparam logic [TW-1:0] TC_ON  = TW'(T_ON - 1);
  localparam logic [TW-1:0] TC_OFF = TW'(T_OFF - 1);

  estado_t           estado_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] lim_q;
  logic [DATA_W-1:0] registro_q;

  logic          pausa_w;
  logic          rodando;
  logic          conta;
  logic          avanca;
  logic          zera;
  logic          fim_t;
  logic [TW-1:0] tc;

`ifdef EXIBE_PAUSA_EN
  assign pausa_w = pausa;
`else
  assign pausa_w = 1'b0;
`endif

  // Timer runs only in the two timed phases; a pause freezes both count and phase change.
  assign rodando = (estado_q == ACESO) || (estado_q == APAGADO);
  assign conta   = rodando && !pausa_w;
  assign avanca  = conta && fim_t;
  assign zera    = !rodando || avanca;
  assign tc      = (estado_q == APAGADO) ? TC_OFF : TC_ON;

  exibe_sequencia_temporizador #(
    .W(TW)
  ) u_temporizador (
    .clock(clock),
    .reset(reset),
    .zera (zera),
    .conta(conta),
    .tc   (tc),
    .fim_t(fim_t)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      addr_q     <= '0;
      lim_q      <= '0;
      registro_q <= '0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (mostra) begin
            estado_q <= CARREGA;
            addr_q   <= '0;
            lim_q    <= limite;
          end
        end
        CARREGA: begin
          registro_q <= mem_dado;
          estado_q   <= ACESO;
        end
        ACESO: begin
          if (avanca) estado_q <= APAGADO;
        end
        APAGADO: begin
          if (avanca) begin
            // Stop on the last index before incrementing, so the address never wraps.
            if (addr_q == lim_q) begin
              estado_q <= FINAL;
            end else begin
              addr_q   <= addr_q + 1'b1;
              estado_q <= CARREGA;
            end
          end
        end
        FINAL: begin
          estado_q <= OCIOSO;
        end
        default: begin
          estado_q <= OCIOSO;
        end
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign leds      = (estado_q == ACESO) ? registro_q : '0;
  assign ocupado   = (estado_q != OCIOSO);
  assign fim       = (estado_q == FINAL);
  assign db_estado = estado_q;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Directed bench for exibe_sequencia with T_ON=3, T_OFF=2; pause scenario under EXIBE_PAUSA_EN.
module tb_exibe_sequencia;

  logic       clock;
  logic       reset;
  logic       mostra;
  logic [3:0] limite;
  logic [3:0] mem_dado;
  logic [3:0] mem_addr;
  logic [3:0] leds;
  logic       ocupado;
  logic       fim;
  logic [3:0] db_estado;
`ifdef EXIBE_PAUSA_EN
  logic       pausa;
`endif

  logic [3:0] mem [16];
  int n_total = 0;
  int n_pass  = 0;

  exibe_sequencia #(
    .ADDR_W(4),
    .DATA_W(4),
    .T_ON  (3),
    .T_OFF (2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .mostra   (mostra),
    .limite   (limite),
    .mem_dado (mem_dado),
    .mem_addr (mem_addr),
    .leds     (leds),
    .ocupado  (ocupado),
    .fim      (fim),
    .db_estado(db_estado)
`ifdef EXIBE_PAUSA_EN
    ,
    .pausa    (pausa)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb mem_dado = mem[mem_addr];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input int c, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle %0d observed=%0h expected=%0h", tag, c, obs, exp);
  endtask

  task automatic check_cycle(input string t, input int c, input int e_leds, input int e_fim,
                             input int e_ocup);
    check({t, " leds"}, c, int'(leds), e_leds);
    check({t, " fim"}, c, int'(fim), e_fim);
    check({t, " ocupado"}, c, int'(ocupado), e_ocup);
  endtask

  // Start a run: mostra high during cycle 0; returns at the start of cycle 1.
  task automatic start(input logic [3:0] lim);
    mostra = 1'b1;
    limite = lim;
    step();
    mostra = 1'b0;
  endtask

  initial begin
    int el, ef, eo, ea;
    for (int i = 0; i < 16; i++) mem[i] = 4'h0;
    mem[0] = 4'h1;
    mem[1] = 4'h2;
    mem[2] = 4'h4;
    mem[3] = 4'h8;
    reset  = 1'b1;
    mostra = 1'b0;
    limite = 4'd0;
`ifdef EXIBE_PAUSA_EN
    pausa  = 1'b0;
`endif
    repeat (3) step();
    check("rst leds", 0, int'(leds), 0);
    check("rst ocupado", 0, int'(ocupado), 0);
    check("rst fim", 0, int'(fim), 0);
    check("rst mem_addr", 0, int'(mem_addr), 0);
    check("rst db_estado", 0, int'(db_estado), 0);
    reset = 1'b0;
    step();

    // Test 1: limite=1
    start(4'd1);
    for (int c = 1; c <= 15; c++) begin
      el = (c >= 2 && c <= 4) ? 1 : (c >= 8 && c <= 10) ? 2 : 0;
      check_cycle("t1", c, el, (c == 13) ? 1 : 0, (c <= 13) ? 1 : 0);
      if (c == 1) check("t1 db_estado", c, int'(db_estado), 1);
      if (c == 5) check("t1 db_estado", c, int'(db_estado), 3);
      if (c == 13) check("t1 db_estado", c, int'(db_estado), 4);
      step();
    end
    check("t1 mem_addr held", 16, int'(mem_addr), 1);

    // Test 2: limite=0, single element
    start(4'd0);
    for (int c = 1; c <= 9; c++) begin
      el = (c >= 2 && c <= 4) ? 1 : 0;
      check_cycle("t2", c, el, (c == 7) ? 1 : 0, (c <= 7) ? 1 : 0);
      check("t2 mem_addr", c, int'(mem_addr), 0);
      step();
    end

    // Test 3: limite=3, four elements
    start(4'd3);
    for (int c = 1; c <= 27; c++) begin
      el = 0;
      for (int e = 0; e < 4; e++)
        if (c >= 2 + 6 * e && c <= 4 + 6 * e) el = 1 << e;
      ea = (c - 1) / 6;
      if (ea > 3) ea = 3;
      check_cycle("t3", c, el, (c == 25) ? 1 : 0, (c <= 25) ? 1 : 0);
      check("t3 mem_addr", c, int'(mem_addr), ea);
      step();
    end

    // Test 4: reset during cycle 9 of a limite=1 run
    start(4'd1);
    for (int c = 1; c <= 16; c++) begin
      if (c <= 9) begin
        el = (c >= 2 && c <= 4) ? 1 : (c >= 8) ? 2 : 0;
        check_cycle("t4", c, el, 0, 1);
      end else begin
        check_cycle("t4 post-reset", c, 0, 0, 0);
        if (c == 10) check("t4 db_estado", c, int'(db_estado), 0);
      end
      reset = (c == 9) ? 1'b1 : 1'b0;
      step();
    end
    reset = 1'b0;

    // Test 5: mostra re-pulse and limite change mid-run are ignored
    start(4'd1);
    for (int c = 1; c <= 15; c++) begin
      el = (c >= 2 && c <= 4) ? 1 : (c >= 8 && c <= 10) ? 2 : 0;
      check_cycle("t5", c, el, (c == 13) ? 1 : 0, (c <= 13) ? 1 : 0);
      mostra = (c == 4) ? 1'b1 : 1'b0;
      if (c == 6) limite = 4'd3;
      step();
    end

    // Test 7: mostra held high restarts right after FINAL
    mostra = 1'b1;
    limite = 4'd0;
    step();
    for (int c = 1; c <= 17; c++) begin
      if (c == 9) mostra = 1'b0;
      ef = (c == 7 || c == 15) ? 1 : 0;
      eo = (c == 8 || c >= 16) ? 0 : 1;
      el = ((c >= 2 && c <= 4) || (c >= 10 && c <= 12)) ? 1 : 0;
      check_cycle("t7", c, el, ef, eo);
      if (c == 8) check("t7 db_estado", c, int'(db_estado), 0);
      if (c == 9) check("t7 db_estado", c, int'(db_estado), 1);
      step();
    end

`ifdef EXIBE_PAUSA_EN
    // Test 6: pausa high in cycles 3-7 of a limite=1 run
    start(4'd1);
    for (int c = 1; c <= 20; c++) begin
      pausa = (c >= 3 && c <= 7) ? 1'b1 : 1'b0;
      el = (c >= 2 && c <= 9) ? 1 : (c >= 13 && c <= 15) ? 2 : 0;
      check_cycle("t6", c, el, (c == 18) ? 1 : 0, (c <= 18) ? 1 : 0);
      step();
    end
    pausa = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
